// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared constants, opcode classes and the write-tracker slot type
//            for the issue-stage hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    // Bubble handed to decode whenever nothing issues
    localparam logic [15:0] c_NOP_INST   = 16'h0800;
    localparam logic [15:0] c_STALL_MAX  = 16'hFFFF;

    // Opcode classes (opcode is fetch_inst[15:11])
    localparam logic [4:0]  c_OP_HALT    = 5'b00000;
    localparam logic [2:0]  c_OP_BR_COND = 3'b001;   // 001xx conditional branches
    localparam logic [2:0]  c_OP_BR_JUMP = 3'b011;   // 011xx jumps / calls

    // One in-flight register write being tracked behind the issue point
    typedef struct packed {
        logic       valid;
        logic [2:0] regIdx;
        logic       isLoad;
    } slot_t;

    // Control instructions open a branch shadow once they issue
    function automatic logic isControl(input logic [4:0] op);
        return (op[4:2] == c_OP_BR_COND) || (op[4:2] == c_OP_BR_JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_src_decode.sv
`default_nettype none
// ============================================================================
// Module   : hazard_src_decode
// Brief    : Classifies an opcode by which source fields it reads:
//            rs = fetch_inst[10:8], rt = fetch_inst[7:5].
// Revision : 1.0 - initial release
// ============================================================================
module hazard_src_decode
    import hazard_scoreboard_pkg::*;
(
    input  logic [15:11] fetch_inst,
    output logic         rs_used,
    output logic         rt_used
);

    // Opcode-to-source-usage table; anything unlisted reads rs only
    always_comb begin
        rs_used = 1'b1;
        rt_used = 1'b0;
        casez (fetch_inst)
            5'b10000, 5'b10011, 5'b1101?, 5'b111??: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            c_OP_HALT, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00110, 5'b11000: begin
                rs_used = 1'b0;
                rt_used = 1'b0;
            end
            default: begin
                rs_used = 1'b1;
                rt_used = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Issue-stage interlock. Tracks in-flight register writes, stalls
//            dependent instructions, injects branch-shadow bubbles, honours
//            flush and HALT, and counts data-hazard stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int PIPE_DEPTH  = 3,
    parameter int BR_SHADOW   = 2,
    parameter int FWD_EN      = 0,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fetch_inst,
    input  logic        inst_valid,
    input  logic        dst_wr,
    input  logic [2:0]  dst_reg,
    input  logic        dst_is_load,
    input  logic        flush,
    output logic [15:0] next_inst,
    output logic        pcNop,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    localparam int c_SHADOW_W = (BR_SHADOW > 0) ? $clog2(BR_SHADOW + 1) : 1;
    localparam logic [c_SHADOW_W-1:0] c_SHADOW_LOAD = c_SHADOW_W'(BR_SHADOW);

    slot_t                  r_slots     [PIPE_DEPTH];
    slot_t                  w_slotsNext [PIPE_DEPTH];
    logic [c_SHADOW_W-1:0]  r_shadow;
    logic                   r_halted;
    logic [15:0]            r_stallCnt;

    logic [4:0]             w_opcode;
    logic [2:0]             w_rs;
    logic [2:0]             w_rt;
    logic                   w_rsUsed;
    logic                   w_rtUsed;
    logic [PIPE_DEPTH-1:0]  w_slotHit;
    logic                   w_dataHazard;
    logic                   w_issue;
    logic                   w_holdPc;
    logic                   w_hazStall;
    logic                   w_flushAct;

    assign w_opcode = fetch_inst[15:11];
    assign w_rs     = fetch_inst[10:8];
    assign w_rt     = fetch_inst[7:5];

    hazard_src_decode u_srcDecode (
        .fetch_inst (fetch_inst[15:11]),
        .rs_used    (w_rsUsed),
        .rt_used    (w_rtUsed)
    );

    // A slot hits when it holds a pending write to a source this instruction reads
    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_slotHit
            assign w_slotHit[gi] = r_slots[gi].valid &&
                ((w_rsUsed && (w_rs == r_slots[gi].regIdx)) ||
                 (w_rtUsed && (w_rt == r_slots[gi].regIdx)));
        end
    endgenerate

    // With forwarding only a load result one cycle old cannot be bypassed
    generate
        if (FWD_EN != 0) begin : g_fwdLoadUse
            assign w_dataHazard = w_slotHit[0] && r_slots[0].isLoad;
        end else begin : g_noFwd
            assign w_dataHazard = |w_slotHit;
        end
    endgenerate

    // Resolve the single winning cause for this cycle in priority order
    always_comb begin
        w_issue    = 1'b0;
        w_holdPc   = 1'b0;
        w_hazStall = 1'b0;
        w_flushAct = 1'b0;
        if (rst) begin
            w_holdPc = 1'b0;
        end else if (r_halted) begin
            w_holdPc = 1'b1;
        end else if (flush) begin
            w_holdPc   = 1'b1;
            w_flushAct = 1'b1;
        end else if (r_shadow != '0) begin
            w_holdPc = 1'b1;
        end else if (!inst_valid) begin
            w_holdPc = 1'b0;
        end else if (w_dataHazard) begin
            w_holdPc   = 1'b1;
            w_hazStall = 1'b1;
        end else begin
            w_issue = 1'b1;
        end
    end

    assign next_inst = w_issue ? fetch_inst : c_NOP_INST;
    assign pcNop     = w_holdPc;
    assign halted    = r_halted & ~rst;
    assign stall_cnt = rst ? 16'h0000 : r_stallCnt;

    // Age the tracker by one slot; flush squashes the youngest entries after the shift
    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            w_slotsNext[i] = '0;
        end
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            w_slotsNext[i] = r_slots[i-1];
        end
        if (w_issue) begin
            w_slotsNext[0] = '{valid: dst_wr, regIdx: dst_reg, isLoad: dst_is_load};
        end
        if (w_flushAct) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (i < FLUSH_DEPTH) begin
                    w_slotsNext[i] = '0;
                end
            end
        end
    end

    // Tracker register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_slots[i] <= w_slotsNext[i];
            end
        end
    end

    // Branch-shadow counter: loaded by an issuing control instruction, cleared by flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_flushAct) begin
            r_shadow <= '0;
        end else if (w_issue && isControl(w_opcode)) begin
            r_shadow <= c_SHADOW_LOAD;
        end else if (r_shadow != '0) begin
            r_shadow <= r_shadow - 1'b1;
        end
    end

    // HALT latches once it issues and only reset releases it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_issue && (w_opcode == c_OP_HALT)) begin
            r_halted <= 1'b1;
        end
    end

    // Saturating count of cycles lost to data hazards only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_hazStall && (r_stallCnt != c_STALL_MAX)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Self-checking bench for hazard_scoreboard. Three configurations
//            share one stimulus stream and are compared every cycle against
//            a cycle-level behavioural model of the issue rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam logic [15:0] c_NOP = 16'h0800;
    localparam int          c_NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] fetchInst;
    logic        instValid;
    logic        dstWr;
    logic [2:0]  dstReg;
    logic        dstIsLoad;
    logic        flush;

    logic [15:0] nextInst  [c_NDUT];
    logic        pcNopO    [c_NDUT];
    logic        haltedO   [c_NDUT];
    logic [15:0] stallCnt  [c_NDUT];

    int nChecks = 0;
    int nPass   = 0;

    // Model state: recent writes per configuration, youngest at index 0
    bit mV [c_NDUT][64];
    int mR [c_NDUT][64];
    bit mL [c_NDUT][64];
    int mShadow [c_NDUT];
    bit mHalt   [c_NDUT];
    int mStall  [c_NDUT];
    int curCause [c_NDUT];

    initial forever #5 clk = ~clk;

    hazard_scoreboard #(.PIPE_DEPTH(3), .BR_SHADOW(2), .FWD_EN(0), .FLUSH_DEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .fetch_inst(fetchInst), .inst_valid(instValid),
        .dst_wr(dstWr), .dst_reg(dstReg), .dst_is_load(dstIsLoad), .flush(flush),
        .next_inst(nextInst[0]), .pcNop(pcNopO[0]), .halted(haltedO[0]), .stall_cnt(stallCnt[0])
    );

    hazard_scoreboard #(.PIPE_DEPTH(3), .BR_SHADOW(2), .FWD_EN(1), .FLUSH_DEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .fetch_inst(fetchInst), .inst_valid(instValid),
        .dst_wr(dstWr), .dst_reg(dstReg), .dst_is_load(dstIsLoad), .flush(flush),
        .next_inst(nextInst[1]), .pcNop(pcNopO[1]), .halted(haltedO[1]), .stall_cnt(stallCnt[1])
    );

    hazard_scoreboard #(.PIPE_DEPTH(64), .BR_SHADOW(0), .FWD_EN(0), .FLUSH_DEPTH(5)) u_dut2 (
        .clk(clk), .rst(rst), .fetch_inst(fetchInst), .inst_valid(instValid),
        .dst_wr(dstWr), .dst_reg(dstReg), .dst_is_load(dstIsLoad), .flush(flush),
        .next_inst(nextInst[2]), .pcNop(pcNopO[2]), .halted(haltedO[2]), .stall_cnt(stallCnt[2])
    );

    function automatic int pd(int k);
        return (k == 2) ? 64 : 3;
    endfunction
    function automatic int bs(int k);
        return (k == 2) ? 0 : 2;
    endfunction
    function automatic int fwd(int k);
        return (k == 1) ? 1 : 0;
    endfunction
    function automatic int fd(int k);
        return (k == 2) ? 5 : 2;
    endfunction

    // Number of source fields read: 2 = rs and rt, 1 = rs only, 0 = none
    function automatic int srcCount(int op);
        if (op == 16 || op == 19 || op >= 26) return 2;
        if (op == 24 || op <= 4 || op == 6) return 0;
        return 1;
    endfunction

    function automatic bit modelHazard(int k);
        int op;
        int n;
        int s [2];
        bit h;
        op   = int'(fetchInst[15:11]);
        n    = srcCount(op);
        s[0] = int'(fetchInst[10:8]);
        s[1] = int'(fetchInst[7:5]);
        h    = 1'b0;
        for (int j = 0; j < pd(k); j++) begin
            if (mV[k][j] && (fwd(k) == 0 || (j == 0 && mL[k][j]))) begin
                for (int m = 0; m < n; m++) begin
                    if (s[m] == mR[k][j]) h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    // 0 reset, 1 halted, 2 flush, 3 shadow, 4 idle, 5 data hazard, 6 issue
    function automatic int modelCause(int k);
        if (rst) return 0;
        if (mHalt[k]) return 1;
        if (flush) return 2;
        if (mShadow[k] > 0) return 3;
        if (!instValid) return 4;
        if (modelHazard(k)) return 5;
        return 6;
    endfunction

    task automatic modelUpdate(int k, int c);
        int op;
        bit issued;
        op = int'(fetchInst[15:11]);
        issued = (c == 6);
        if (rst) begin
            for (int j = 0; j < 64; j++) mV[k][j] = 1'b0;
            mShadow[k] = 0;
            mHalt[k]   = 1'b0;
            mStall[k]  = 0;
        end else begin
            for (int j = pd(k) - 1; j > 0; j--) begin
                mV[k][j] = mV[k][j-1];
                mR[k][j] = mR[k][j-1];
                mL[k][j] = mL[k][j-1];
            end
            mV[k][0] = issued && dstWr;
            mR[k][0] = int'(dstReg);
            mL[k][0] = dstIsLoad;
            if (c == 2) begin
                for (int j = 0; j < fd(k) && j < pd(k); j++) mV[k][j] = 1'b0;
                mShadow[k] = 0;
            end else if (issued && ((op >> 2) == 1 || (op >> 2) == 3)) begin
                mShadow[k] = bs(k);
            end else if (mShadow[k] > 0) begin
                mShadow[k] = mShadow[k] - 1;
            end
            if (issued && op == 0) mHalt[k] = 1'b1;
            if (c == 5 && mStall[k] < 65535) mStall[k] = mStall[k] + 1;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are already applied; check at the falling edge, advance the model at the rising edge
    task automatic stepCycle();
        int c;
        @(negedge clk);
        for (int k = 0; k < c_NDUT; k++) begin
            c = modelCause(k);
            curCause[k] = c;
            checkVal($sformatf("next_inst[%0d]", k), 32'(nextInst[k]), 32'((c == 6) ? fetchInst : c_NOP));
            checkVal($sformatf("pcNop[%0d]", k), 32'(pcNopO[k]),
                     32'((c == 1 || c == 2 || c == 3 || c == 5) ? 1 : 0));
            checkVal($sformatf("halted[%0d]", k), 32'(haltedO[k]), 32'(rst ? 1'b0 : mHalt[k]));
            checkVal($sformatf("stall_cnt[%0d]", k), 32'(stallCnt[k]), 32'(rst ? 0 : mStall[k]));
        end
        @(posedge clk);
        for (int k = 0; k < c_NDUT; k++) modelUpdate(k, curCause[k]);
        #1;
    endtask

    task automatic drive(bit r, logic [15:0] inst, bit v, bit w, int dr, bit ld, bit fl);
        rst       = r;
        fetchInst = inst;
        instValid = v;
        dstWr     = w;
        dstReg    = 3'(dr);
        dstIsLoad = ld;
        flush     = fl;
        stepCycle();
    endtask

    initial begin
        int guard;
        logic [15:0] inst;
        logic [4:0]  op;
        for (int k = 0; k < c_NDUT; k++) begin
            for (int j = 0; j < 64; j++) begin
                mV[k][j] = 1'b0;
                mR[k][j] = 0;
                mL[k][j] = 1'b0;
            end
            mShadow[k] = 0;
            mHalt[k]   = 1'b0;
            mStall[k]  = 0;
        end

        repeat (3) drive(1, 16'h0000, 0, 0, 0, 0, 0);

        // ADDI r1 then dependent ADD r2,r1,r3 held until it issues
        drive(0, 16'h4005, 1, 1, 1, 0, 0);
        repeat (4) drive(0, 16'h8160, 1, 1, 2, 0, 0);
        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        checkVal("req032_stall_cnt", 32'(stallCnt[0]), 32'd3);
        checkVal("req033_fwd_alu_no_stall", 32'(stallCnt[1]), 32'd0);

        // Same with a load producer: one load-use bubble under forwarding
        drive(0, 16'h4005, 1, 1, 1, 1, 0);
        repeat (2) drive(0, 16'h8160, 1, 1, 2, 0, 0);
        checkVal("req033_load_use_stall", 32'(stallCnt[1]), 32'd1);
        repeat (4) drive(0, 16'h0000, 0, 0, 0, 0, 0);

        // Conditional branch followed by independent work: two shadow bubbles
        drive(0, 16'h2D04, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 16'h4005, 1, 1, 4, 0, 0);
        repeat (4) drive(0, 16'h0000, 0, 0, 0, 0, 0);

        // Linking jump writes r7, flushed in its first shadow cycle; reader of r7 issues next
        drive(0, 16'h6500, 1, 1, 7, 0, 0);
        drive(0, 16'h8700, 1, 0, 0, 0, 1);
        drive(0, 16'h8700, 1, 0, 0, 0, 0);
        checkVal("req035_issue_after_flush", 32'(nextInst[0]), 32'h8700);
        repeat (4) drive(0, 16'h0000, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            op = 5'($urandom_range(1, 31));
            inst = {op, 1'b0, 2'($urandom), 1'b0, 2'($urandom), 5'($urandom)};
            drive(($urandom_range(0, 127) == 0), inst, ($urandom_range(0, 7) != 0),
                  1'($urandom), $urandom_range(0, 3), 1'($urandom),
                  ($urandom_range(0, 15) == 0));
        end
        repeat (4) drive(0, 16'h0000, 0, 0, 0, 0, 0);

        // HALT then reset release
        drive(0, 16'h0000, 1, 0, 0, 0, 0);
        repeat (4) drive(0, 16'h4005, 1, 1, 1, 0, 0);
        checkVal("req036_halted", 32'(haltedO[0]), 32'd1);
        checkVal("req036_pcnop_held", 32'(pcNopO[0]), 32'd1);
        repeat (2) drive(1, 16'h0000, 0, 0, 0, 0, 0);
        drive(0, 16'h0000, 0, 0, 0, 0, 0);
        checkVal("req036_halt_cleared", 32'(haltedO[0]), 32'd0);

        // Self-dependent writes keep the deep tracker stalling until the counter saturates
        guard = 0;
        while (mStall[2] < 65535 && guard < 70000) begin
            drive(0, 16'h4100, 1, 1, 1, 0, 0);
            guard++;
        end
        if (guard >= 70000) checkVal("sat_cycle_budget", 32'(guard), 32'd0);
        repeat (70) drive(0, 16'h4100, 1, 1, 1, 0, 0);
        checkVal("req037_saturated", 32'(stallCnt[2]), 32'hFFFF);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter PIPE_DEPTH, default 3, meaning number of in-flight write slots tracked after issue (min 1).
REQ-002 Parameter BR_SHADOW, default 2, meaning NOP cycles injected after a control instruction issues (0 disables).
REQ-003 Parameter FWD_EN, default 0, meaning 0 stalls on any tracked match and 1 stalls on load-use in slot 0 only.
REQ-004 Parameter FLUSH_DEPTH, default 2, meaning youngest slots invalidated on flush (1..PIPE_DEPTH).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 fetch_inst  input  16  instruction offered for issue.
REQ-008 inst_valid  input  1  fetch_inst is meaningful this cycle.
REQ-009 dst_wr / dst_reg / dst_is_load  input  1/3/1  decoder info for fetch_inst: writes a register, which one, and whether it is a load.
REQ-010 flush  input  1  squash request from branch resolution.
REQ-011 next_inst  output  16  instruction passed to decode, or NOP 16'h0800.
REQ-012 pcNop  output  1  hold PC this cycle.
REQ-013 halted  output  1  HALT has issued.
REQ-014 stall_cnt  output  16  saturating count of data-hazard stall cycles.

Function
REQ-015 Sources by opcode[15:11]: 10000, 10011 read [10:8] and [7:5]; 1101x and 111xx read [10:8] and [7:5]; 11000, 00000, 00001, 00010, 00011, 00100, 00110 read none; all others read [10:8].
REQ-016 Tracker is PIPE_DEPTH slots {valid, reg, is_load}; every cycle slot i+1 takes slot i, the oldest is dropped, and slot 0 takes {dst_wr, dst_reg, dst_is_load} if the instruction issued, else invalid.
REQ-017 A data hazard exists when FWD_EN=0 and any used source equals a valid slot reg, or when FWD_EN=1 and a used source equals slot 0 reg with valid and is_load set.
REQ-018 Priority per cycle is rst, then halted, then flush, then shadow>0, then !inst_valid, then data hazard, then issue.
REQ-019 Issue means next_inst=fetch_inst and pcNop=0.
REQ-020 Halted, flush, shadow>0 and data hazard each give next_inst=NOP and pcNop=1.
REQ-021 !inst_valid gives next_inst=NOP and pcNop=0.
REQ-022 Issue of opcode 001xx or 011xx loads the shadow counter with BR_SHADOW the next cycle.
REQ-023 The shadow counter decrements once per cycle while nonzero.
REQ-024 Issue of opcode 00000 sets halted the next cycle; halted holds until rst.
REQ-025 Flush clears the shadow counter and forces slot 0 plus slots 1..FLUSH_DEPTH-1 of the post-shift state invalid; flush wins over a simultaneous branch issue.
REQ-026 stall_cnt increments by 1 on each cycle whose stall cause is data hazard, and holds at 16'hFFFF.
REQ-027 The hazard check is combinational from the current tracker state, with zero-cycle latency from fetch_inst to next_inst and pcNop.

Reset
REQ-028 While rst=1: next_inst=NOP, pcNop=0, halted=0, stall_cnt=0, shadow=0, all slots invalid; the cycle after deassertion is fully operational.
REQ-029 rst mid-stall or mid-shadow discards all pending state with no residual NOPs.

Structure
REQ-030 The shared package holds the NOP constant, opcode class constants and the slot struct typedef.
REQ-031 The source-usage decode is one sub-module, hazard_src_decode (fetch_inst -> rs_used, rt_used).

Verification
REQ-032 ADDI r1 (dst_wr=1, reg 1) issues, then ADD r2,r1,r3 offered, FWD_EN=0, PIPE_DEPTH=3 -> exactly 3 stall cycles, issue on the 4th, stall_cnt=3.
REQ-033 Same sequence with FWD_EN=1 and dst_is_load=0 -> no stall; with dst_is_load=1 -> exactly 1 stall cycle.
REQ-034 BEQZ issues with BR_SHADOW=2 -> next 2 cycles next_inst=16'h0800 and pcNop=1 with stall_cnt unchanged, then normal issue.
REQ-035 flush asserted in the first shadow cycle after a branch -> shadow cleared and slots 0..1 invalidated, so an instruction dependent on a squashed write issues the cycle after flush.
REQ-036 HALT issues -> halted=1 and pcNop=1 on all later cycles; rst pulse returns halted=0.
REQ-037 stall_cnt preloaded to 16'hFFFE by 2+ hazard cycles -> holds 16'hFFFF.
